// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay line: depth clamping and the
// bit width of one stage record {vld, data[NCH]}.
package delay_pkg;

  // Limit a requested depth to the number of physical stages available.
  function automatic int clamp_len(input int req, input int max);
    return (req > max) ? max : req;
  endfunction

  // Width of one packed stage record: one valid bit plus NCH data words.
  function automatic int stage_bits(input int dw, input int nch);
    return 1 + dw * nch;
  endfunction

endpackage

// File: rtl/delay_tap_sel.sv
// Output tap selector for the delay line. This is a purely combinational
// MAX_LEN:1 mux plus a zero-depth bypass. It is kept separate so that a
// pipelined or one-hot variant can replace it without touching the stages.
module delay_tap_sel
  import delay_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NCH     = 2,
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1),
  parameter int SW      = stage_bits(DW, NCH)
) (
  input  logic [LW-1:0]                len_i,
  input  logic [MAX_LEN-1:0][SW-1:0]   stages_i,
  input  logic                         en_i,
  input  logic                         in_valid_i,
  input  logic [NCH-1:0][DW-1:0]       in_data_i,
  output logic                         out_valid_o,
  output logic [NCH-1:0][DW-1:0]       out_data_o
);

  // Pick stage len-1, or pass the input straight through when depth is zero.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    if (len_i == '0) begin
      out_valid_o = in_valid_i & en_i;
      out_data_o  = in_data_i;
    end else begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (len_i == LW'(k + 1)) begin
          {out_valid_o, out_data_o} = stages_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel delay line with a run-time programmable depth. All channels
// share one valid flag, one enable and one depth. A depth write flushes the
// valid bits of the line so that no stale beat is emitted at the new depth.
module prog_delay_line
  import delay_pkg::*;
#(
  parameter int DW      = 8,
  parameter int NCH     = 2,
  parameter int MAX_LEN = 16,
  parameter int DEF_LEN = 4,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [NCH-1:0][DW-1:0] in_data,
  input  logic                   cfg_wr,
  input  logic [LW-1:0]          cfg_len,
  output logic                   out_valid,
  output logic [NCH-1:0][DW-1:0] out_data,
  output logic [LW-1:0]          cur_len,
  output logic                   primed,
  output logic                   cfg_err
);

  localparam int SW = stage_bits(DW, NCH);

  typedef struct packed {
    logic                   vld;
    logic [NCH-1:0][DW-1:0] data;
  } stage_t;

  stage_t [MAX_LEN-1:0] stage_q, stage_d;
  logic   [LW-1:0]      cur_len_q, cur_len_d;
  logic   [LW-1:0]      fill_q, fill_d;
  logic                 cfg_err_q, cfg_err_d;

  // Shift on enable; a depth write clears every valid bit except the beat
  // entering stage 0 in the same cycle, which keeps its own valid flag.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0].vld  = in_valid;
      stage_d[0].data = in_data;
      for (int k = 1; k < MAX_LEN; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
    if (cfg_wr) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        stage_d[k].vld = 1'b0;
      end
      if (en) begin
        stage_d[0].vld = in_valid;
      end
    end
  end

  // Depth, overflow pulse and fill count; fill saturates at the active depth.
  always_comb begin
    cur_len_d = cur_len_q;
    fill_d    = fill_q;
    cfg_err_d = 1'b0;
    if (cfg_wr) begin
      cur_len_d = LW'(clamp_len(int'(cfg_len), MAX_LEN));
      cfg_err_d = (int'(cfg_len) > MAX_LEN);
      fill_d    = en ? LW'(1) : '0;
    end else if (en && (fill_q < cur_len_q)) begin
      fill_d = fill_q + LW'(1);
    end
  end

  // State registers; reset wins over any depth write or enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q   <= '0;
      cur_len_q <= LW'(DEF_LEN);
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      cur_len_q <= cur_len_d;
      fill_q    <= fill_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  delay_tap_sel #(
    .DW      (DW),
    .NCH     (NCH),
    .MAX_LEN (MAX_LEN),
    .LW      (LW),
    .SW      (SW)
  ) u_tap_sel (
    .len_i       (cur_len_q),
    .stages_i    (stage_q),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

  assign cur_len = cur_len_q;
  assign cfg_err = cfg_err_q;
  assign primed  = (cur_len_q == '0) || (fill_q == cur_len_q);

endmodule

// File: tb/tb_prog_delay_line.sv
// Self-checking bench for prog_delay_line. The reference model logs every
// accepted beat and the log position of the last flush; the expected output
// is the beat accepted cur_len enabled cycles ago, valid only if it was
// accepted since that flush.
module tb_prog_delay_line;

  localparam int DW      = 8;
  localparam int NCH     = 2;
  localparam int MAX_LEN = 16;
  localparam int DEF_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  typedef logic [NCH-1:0][DW-1:0] beat_t;

  typedef struct packed {
    logic          vld;
    logic          primed;
    logic          err;
    logic [LW-1:0] len;
    beat_t         data;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, en, in_valid, cfg_wr;
  beat_t         in_data;
  logic [LW-1:0] cfg_len;
  logic          out_valid, primed, cfg_err;
  beat_t         out_data;
  logic [LW-1:0] cur_len;

  obs_t obs, expv, rstv;

  beat_t logData[$];
  bit    logVld[$];
  int    flushBase, curLen;
  bit    errExp;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  prog_delay_line #(
    .DW(DW), .NCH(NCH), .MAX_LEN(MAX_LEN), .DEF_LEN(DEF_LEN), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .cfg_wr(cfg_wr), .cfg_len(cfg_len), .out_valid(out_valid),
    .out_data(out_data), .cur_len(cur_len), .primed(primed), .cfg_err(cfg_err)
  );

  assign obs = {out_valid, primed, cfg_err, cur_len, out_data};

  function automatic beat_t mk(input logic [7:0] x);
    beat_t b;
    b[0] = x;
    b[1] = x ^ 8'hFF;
    return b;
  endfunction

  // Expected outputs for the current cycle from the beat log and inputs.
  function automatic obs_t expected();
    obs_t e;
    int   idx;
    e.len = LW'(curLen);
    e.err = errExp;
    if (curLen == 0) begin
      e.data   = in_data;
      e.vld    = in_valid & en;
      e.primed = 1'b1;
    end else begin
      idx = logData.size() - curLen;
      if (idx < 0) begin
        e.data = '0;
        e.vld  = 1'b0;
      end else begin
        e.data = logData[idx];
        e.vld  = logVld[idx] && (idx >= flushBase);
      end
      e.primed = ((logData.size() - flushBase) >= curLen);
    end
    return e;
  endfunction

  // Present inputs mid-cycle and let combinational paths settle.
  task automatic drive(input bit r, input bit e, input bit v, input beat_t d,
                       input bit w, input int l);
    @(negedge clk);
    rst      = r;
    en       = e;
    in_valid = v;
    in_data  = d;
    cfg_wr   = w;
    cfg_len  = LW'(l);
    #1;
  endtask

  // Clock edge: apply the same inputs to the reference model.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      logData.delete();
      logVld.delete();
      flushBase = 0;
      curLen    = DEF_LEN;
      errExp    = 1'b0;
    end else begin
      errExp = cfg_wr && (int'(cfg_len) > MAX_LEN);
      if (cfg_wr) begin
        flushBase = logData.size();
        curLen    = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
      end
      if (en) begin
        logData.push_back(in_data);
        logVld.push_back(in_valid);
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, '0, 0, 0);
    advance();
    drive(1, 1, 1, mk(8'h55), 1, 7);
    advance();
    drive(0, 0, 0, '0, 0, 0);
    testsRun++;
    if (obs !== rstv) begin
      failCount++;
      $display("[TB] FAIL reset_values got=%h exp=%h", obs, rstv);
    end
    advance();
  endtask

  task automatic test_default_latency();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 1, mk(8'(8'h10 + k)), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL default_latency k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (k == 4) begin
        testsRun++;
        if (out_data[0] !== 8'h10 || out_valid !== 1'b1 || primed !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL first_beat_at_4 got data=%h vld=%b primed=%b exp 10/1/1",
                   out_data[0], out_valid, primed);
        end
      end
      advance();
    end
  endtask

  task automatic test_enable_gating();
    bit enSeq[8] = '{1, 0, 1, 0, 1, 0, 0, 1};
    drive(0, 0, 0, '0, 1, 3);
    advance();
    for (int k = 0; k < 8; k++) begin
      drive(0, enSeq[k], (k == 0), (k == 0) ? mk(8'hA5) : mk(8'(k)), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL enable_gating k=%0d got=%h exp=%h", k, obs, expv);
      end
      if (k == 5 || k == 6) begin
        testsRun++;
        if (out_data[0] !== 8'hA5 || out_valid !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL gated_beat k=%0d got data=%h vld=%b exp a5/1",
                   k, out_data[0], out_valid);
        end
      end
      advance();
    end
  endtask

  task automatic test_reprogram();
    drive(0, 0, 0, '0, 1, 4);
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 1, beat_t'($urandom), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL reprog_fill k=%0d got=%h exp=%h", k, obs, expv);
      end
      advance();
    end
    for (int j = 0; j < 6; j++) begin
      if (j == 0) drive(0, 1, 1, mk(8'h77), 1, 2);
      else        drive(0, 1, 0, mk(8'(j)), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL reprog j=%0d got=%h exp=%h", j, obs, expv);
      end
      if (j == 1) begin
        testsRun++;
        if (cur_len !== LW'(2) || out_valid !== 1'b0 || primed !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL reprog_flush got len=%0d vld=%b primed=%b exp 2/0/0",
                   cur_len, out_valid, primed);
        end
      end
      if (j == 2) begin
        testsRun++;
        if (out_data[0] !== 8'h77 || out_valid !== 1'b1 || primed !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL reprog_beat got data=%h vld=%b primed=%b exp 77/1/1",
                   out_data[0], out_valid, primed);
        end
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, 0, '0, 1, MAX_LEN + 3);
    advance();
    for (int j = 0; j < 19; j++) begin
      if (j == 0) drive(0, 1, 1, mk(8'h3C), 0, 0);
      else        drive(0, 1, 0, mk(8'(j)), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL overflow j=%0d got=%h exp=%h", j, obs, expv);
      end
      if (j == 0) begin
        testsRun++;
        if (cur_len !== LW'(MAX_LEN) || cfg_err !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL overflow_clamp got len=%0d err=%b exp %0d/1",
                   cur_len, cfg_err, MAX_LEN);
        end
      end
      if (j == 1) begin
        testsRun++;
        if (cfg_err !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL overflow_pulse got err=%b exp 0", cfg_err);
        end
      end
      if (j == MAX_LEN) begin
        testsRun++;
        if (out_data[0] !== 8'h3C || out_valid !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL max_latency got data=%h vld=%b exp 3c/1",
                   out_data[0], out_valid);
        end
      end
      advance();
    end
  endtask

  task automatic test_zero_depth();
    drive(0, 0, 0, '0, 1, 0);
    advance();
    for (int k = 0; k < 10; k++) begin
      drive(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            beat_t'($urandom), 0, 0);
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL zero_depth k=%0d got=%h exp=%h", k, obs, expv);
      end
      testsRun++;
      if (out_data !== in_data || out_valid !== (in_valid & en) || primed !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL bypass k=%0d got data=%h vld=%b primed=%b exp data=%h vld=%b primed=1",
                 k, out_data, out_valid, primed, in_data, in_valid & en);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, '0, 1, 8);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, mk(8'(8'hC0 + k)), 0, 0);
      advance();
    end
    drive(1, 1, 1, mk(8'hEE), 0, 0);
    advance();
    for (int j = 0; j < 12; j++) begin
      drive(0, 1, 0, mk(8'(j)), 0, 0);
      if (j == 0) begin
        testsRun++;
        if (obs !== rstv) begin
          failCount++;
          $display("[TB] FAIL reset_mid_values got=%h exp=%h", obs, rstv);
        end
      end
      expv = expected();
      testsRun++;
      if (obs !== expv || out_valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_mid_drain j=%0d got=%h exp=%h", j, obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 1)), beat_t'($urandom),
            ($urandom_range(0, 15) == 0), int'($urandom_range(0, (1 << LW) - 1)));
      expv = expected();
      testsRun++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL random i=%0d got=%h exp=%h", i, obs, expv);
      end
      advance();
    end
  endtask

  initial begin
    rstv.vld    = 1'b0;
    rstv.primed = (DEF_LEN == 0);
    rstv.err    = 1'b0;
    rstv.len    = LW'(DEF_LEN);
    rstv.data   = '0;
    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cfg_wr   = 1'b0;
    cfg_len  = '0;
    test_reset();
    test_default_latency();
    test_enable_gating();
    test_reprogram();
    test_overflow();
    test_zero_depth();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
